// File: rtl/spatz_issue_ctrl.sv
// Issue controller between a scalar core and the Spatz vector unit: buffers vector
// requests, issues them in order, and writes scalar results back or flushes on an illegal instruction.
module spatz_issue_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ELEN  = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [31:0]     req_instr_i,
  input  logic [ELEN-1:0] req_rs1_i,
  input  logic [ELEN-1:0] req_rs2_i,
  input  logic [4:0]      req_rd_addr_i,
  input  logic            req_use_rd_i,
  output logic            spatz_valid_o,
  input  logic            spatz_ready_i,
  output logic [31:0]     spatz_instr_o,
  output logic [ELEN-1:0] spatz_rs1_o,
  output logic [ELEN-1:0] spatz_rs2_o,
  input  logic            rsp_valid_i,
  output logic            rsp_ready_o,
  input  logic [ELEN-1:0] rsp_data_i,
  input  logic            rsp_illegal_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [4:0]      wb_addr_o,
  output logic [ELEN-1:0] wb_data_o,
  output logic            illegal_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fifo_instr_q   [DEPTH];
  logic [ELEN-1:0] fifo_rs1_q     [DEPTH];
  logic [ELEN-1:0] fifo_rs2_q     [DEPTH];
  logic [4:0]      fifo_rd_addr_q [DEPTH];
  logic            fifo_use_rd_q  [DEPTH];
  logic [PW-1:0]   fifo_wptr_q, fifo_rptr_q;
  logic [CW-1:0]   fifo_cnt_q;
  logic [4:0]      pend_rd_addr_q [DEPTH];
  logic            pend_use_rd_q  [DEPTH];
  logic [PW-1:0]   pend_wptr_q, pend_rptr_q;
  logic [CW-1:0]   outst_q, outst_d;
  logic            wb_valid_q, illegal_q;
  logic [4:0]      wb_addr_q;
  logic [ELEN-1:0] wb_data_q;
  logic            fifo_full, fifo_empty, push, issue, rsp_acc, flush_fifo;

  // Handshake qualifiers; everything here derives from registered state plus the peer's inputs
  assign fifo_full     = (fifo_cnt_q == CW'(DEPTH));
  assign fifo_empty    = (fifo_cnt_q == '0);
  assign req_ready_o   = !rst_i && (state_q == RUN) && !fifo_full;
  assign spatz_valid_o = !rst_i && (state_q == RUN) && !fifo_empty && (outst_q != CW'(DEPTH));
  assign spatz_instr_o = spatz_valid_o ? fifo_instr_q[fifo_rptr_q] : '0;
  assign spatz_rs1_o   = spatz_valid_o ? fifo_rs1_q[fifo_rptr_q]   : '0;
  assign spatz_rs2_o   = spatz_valid_o ? fifo_rs2_q[fifo_rptr_q]   : '0;
  assign rsp_ready_o   = (state_q == FLUSH) || !wb_valid_q || wb_ready_i;
  assign push          = req_valid_i && req_ready_o;
  assign issue         = spatz_valid_o && spatz_ready_i;
  assign rsp_acc       = rsp_valid_i && rsp_ready_o && (outst_q != '0);
  assign wb_valid_o    = wb_valid_q;
  assign wb_addr_o     = wb_addr_q;
  assign wb_data_o     = wb_data_q;
  assign illegal_o     = illegal_q;

  // Next state: an illegal response kills queued work and drains whatever is still in flight
  always_comb begin
    state_d    = state_q;
    flush_fifo = 1'b0;
    outst_d    = outst_q + CW'(issue) - CW'(rsp_acc);
    case (state_q)
      RUN: begin
        if (rsp_acc && rsp_illegal_i) begin
          flush_fifo = 1'b1;
          if (outst_d != '0) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (outst_d == '0) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
    end
  end

  // Queue pointers; pending occupancy always equals the outstanding count
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_fifo) begin
      fifo_wptr_q <= '0;
      fifo_rptr_q <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      if (push)  fifo_wptr_q <= fifo_wptr_q + PW'(1);
      if (issue) fifo_rptr_q <= fifo_rptr_q + PW'(1);
      fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(issue);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_wptr_q <= '0;
      pend_rptr_q <= '0;
    end else begin
      if (issue)   pend_wptr_q <= pend_wptr_q + PW'(1);
      if (rsp_acc) pend_rptr_q <= pend_rptr_q + PW'(1);
    end
  end

  // Payload storage needs no reset: every read is qualified by an occupancy count
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr_q[fifo_wptr_q]   <= req_instr_i;
      fifo_rs1_q[fifo_wptr_q]     <= req_rs1_i;
      fifo_rs2_q[fifo_wptr_q]     <= req_rs2_i;
      fifo_rd_addr_q[fifo_wptr_q] <= req_rd_addr_i;
      fifo_use_rd_q[fifo_wptr_q]  <= req_use_rd_i;
    end
    if (issue) begin
      pend_rd_addr_q[pend_wptr_q] <= fifo_rd_addr_q[fifo_rptr_q];
      pend_use_rd_q[pend_wptr_q]  <= fifo_use_rd_q[fifo_rptr_q];
    end
  end

  // Writeback register and illegal pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      illegal_q <= rsp_acc && rsp_illegal_i && (state_q == RUN);
      if (rsp_acc && (state_q == RUN) && !rsp_illegal_i && pend_use_rd_q[pend_rptr_q]) begin
        wb_valid_q <= 1'b1;
        wb_addr_q  <= pend_rd_addr_q[pend_rptr_q];
        wb_data_q  <= rsp_data_i;
      end else if (wb_ready_i) begin
        wb_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/spatz_issue_ctrl.md
SPATZ_ISSUE_CTRL -- requirements
Module: spatz_issue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction-queue entries and maximum outstanding instructions (power of two, >=2).
REQ-002 SHALL have parameter ELEN, default 32, meaning scalar operand/result width.
REQ-003 SHALL have port clk_i  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid_i  in  1  core offers a vector instruction.
REQ-006 SHALL have port req_ready_o  out  1  queue accepts the instruction.
REQ-007 SHALL have ports req_instr_i  in  32, req_rs1_i  in  ELEN, req_rs2_i  in  ELEN, req_rd_addr_i  in  5, req_use_rd_i  in  1, carrying the instruction word, operands, destination and writeback flag.
REQ-008 SHALL have ports spatz_valid_o  out  1, spatz_ready_i  in  1, spatz_instr_o  out  32, spatz_rs1_o  out  ELEN, spatz_rs2_o  out  ELEN, forming the issue channel to the vector unit.
REQ-009 SHALL have ports rsp_valid_i  in  1, rsp_ready_o  out  1, rsp_data_i  in  ELEN, rsp_illegal_i  in  1, forming the in-order response channel from the vector unit.
REQ-010 SHALL have ports wb_valid_o  out  1, wb_ready_i  in  1, wb_addr_o  out  5, wb_data_o  out  ELEN, forming the scalar register writeback channel.
REQ-011 SHALL have port illegal_o  out  1  one-cycle pulse: vector unit rejected an instruction.

Function
REQ-012 SHALL buffer accepted requests in a DEPTH-entry FIFO; transfer occurs when req_valid_i && req_ready_o.
REQ-013 SHALL drive req_ready_o = (state==RUN) && !fifo_full; it SHALL NOT depend combinationally on spatz_ready_i.
REQ-014 SHALL drive spatz_valid_o from registered FIFO head: request accepted in cycle N appears at the earliest in cycle N+1.
REQ-015 SHALL hold spatz_* stable while spatz_valid_o && !spatz_ready_i.
REQ-016 SHALL gate issue: spatz_valid_o = fifo_not_empty && (state==RUN) && (outstanding < DEPTH).
REQ-017 SHALL, on issue handshake, pop the FIFO and push {rd_addr, use_rd} into a DEPTH-entry pending queue.
REQ-018 SHALL keep an outstanding counter 0..DEPTH: +1 on issue, -1 on response accept, unchanged when both occur in the same cycle.
REQ-019 SHALL drive rsp_ready_o = (!wb_valid_o || wb_ready_i) in RUN, and 1 in FLUSH.
REQ-020 SHALL, on response accept with rsp_illegal_i=0 and use_rd=1, register wb_valid_o=1, wb_addr_o=rd_addr, wb_data_o=rsp_data_i in the next cycle; use_rd=0 responses SHALL produce no writeback.
REQ-021 SHALL hold wb_* stable until wb_ready_i; it SHALL accept a new response in the same cycle the held writeback retires.
REQ-022 SHALL implement FSM states RUN, FLUSH; reset state RUN.
REQ-023 SHALL, on response accept with rsp_illegal_i=1 in RUN: pulse illegal_o in the next cycle, discard that response, clear the instruction FIFO, and go to FLUSH if outstanding after this accept is >0, otherwise stay in RUN.
REQ-024 SHALL, in FLUSH, accept and discard all responses (no writeback, no further illegal_o), block issue and requests, and return to RUN in the cycle after outstanding reaches 0.
REQ-025 SHALL accept a simultaneous push and pop on a non-full, non-empty FIFO in one cycle; on a full FIFO, push SHALL NOT occur.
REQ-026 SHALL wrap FIFO and pending-queue pointers modulo DEPTH.
REQ-027 SHALL ignore rsp_valid_i when outstanding==0 (rsp_ready_o still as specified; no state change).

Reset
REQ-028 SHALL, while rst_i=1 at a clock edge, empty both queues, set outstanding=0, state=RUN, and drive req_ready_o=0, spatz_valid_o=0, wb_valid_o=0, illegal_o=0, wb_addr_o=0, wb_data_o=0, spatz_instr_o=0 during reset.
REQ-029 SHALL, on reset asserted mid-operation, drop all buffered, outstanding and pending writeback state without emitting further wb_valid_o or illegal_o.

Verification
REQ-030 SHALL cover: one request {instr=0xC0002057, rs1=0x10, use_rd=1, rd=5}, spatz_ready_i=1, response data 0x10 -> spatz_valid_o cycle N+1, wb_valid_o with addr 5, data 0x10 one cycle after response.
REQ-031 SHALL cover: spatz_ready_i=0, 5 requests with DEPTH=4 -> 4 accepted, req_ready_o=0 on 5th; release ready -> issue in order, outstanding peaks at 4.
REQ-032 SHALL cover: 3 issued, 2 queued, first response rsp_illegal_i=1 -> illegal_o single pulse, queue cleared, FLUSH discards 2 responses, RUN thereafter, zero wb_valid_o.
REQ-033 SHALL cover: wb_ready_i=0 for 3 cycles with back-to-back responses -> rsp_ready_o=0 while wb held, wb_* stable, no data loss, in-order writeback.
REQ-034 SHALL cover: rst_i asserted with 2 outstanding and wb_valid_o=1 -> all outputs zero next cycle; later responses ignored; fresh request completes normally.
REQ-035 SHALL cover: use_rd=0 instruction response -> outstanding decrements, no writeback.
